vend_change_ctrl: RTL and testbench

Change-dispensing controller for the vending machine. It accepts a change request expressed in Rs.5 units and drives two coin hoppers (Rs.10 and Rs.5) one coin at a time over a pulse/acknowledge handshake. It tracks the inventory of each hopper and reports any shortfall. It sits between the vending FSM's change output and the physical hopper drivers.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_coin_counter.sv | 30 +++
 rtl/vend_change_ctrl.sv | 139 +++++++++++++
 tb/tb_vend_change_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, hopper
// select codes and the coin values in Rs.5 units.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_PULSE,
    ST_WAIT_ACK,
    ST_DONE
  } vend_state_t;

  localparam logic SEL_RS5  = 1'b0;
  localparam logic SEL_RS10 = 1'b1;

  localparam int AMT_W = 3;
  localparam logic [AMT_W-1:0] UNITS_RS5  = 3'd1;
  localparam logic [AMT_W-1:0] UNITS_RS10 = 3'd2;

  function automatic logic [AMT_W-1:0] coin_units(input logic sel);
    return (sel == SEL_RS10) ? UNITS_RS10 : UNITS_RS5;
  endfunction

endpackage

// File: rtl/vend_coin_counter.sv
// Per-hopper inventory: loads INIT on reset, adds refills with saturation and
// takes one coin off on a dispense; both may land in the same cycle.
module vend_coin_counter #(
  parameter int               CNT_W = 4,
  parameter logic [CNT_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill,
  input  logic [CNT_W-1:0] refill_cnt,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W:0] sum;

  // One spare bit holds the refill overflow; dec only follows a nonzero count
  always_comb begin
    sum = {1'b0, cnt} + (refill ? {1'b0, refill_cnt} : '0);
    if (dec) sum = sum - {{CNT_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= INIT;
    else if (refill || dec) cnt <= (sum > MAX) ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/vend_change_ctrl.sv
// Change dispenser: greedy Rs.10/Rs.5 payout over a pulse/ack hopper handshake.
// Define VEND_CHG_JAM_TIMEOUT_EN to abort a dispense after TIMEOUT ack-less cycles.
module vend_change_ctrl
  import vend_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int INIT10  = 8,
  parameter int INIT5   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_amt,
  output logic             req_ready,
  output logic             disp_pulse,
  output logic             disp_sel,
  input  logic             disp_ack,
  input  logic             refill_valid,
  input  logic             refill_sel,
  input  logic [CNT_W-1:0] refill_cnt,
  output logic             done,
  output logic [2:0]       short_amt,
  output logic             err_short,
  output logic             err_jam,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5
);

  vend_state_t      state, state_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic             sel, sel_n;
  logic             jam_n, timed_out, ack_ok;
  logic             esh_q;

  assign ack_ok = (state == ST_WAIT_ACK) && disp_ack;

  vend_coin_counter #(.CNT_W(CNT_W), .INIT(CNT_W'(INIT10))) u_cnt10 (
    .clk(clk), .rst(rst),
    .refill(refill_valid && (refill_sel == SEL_RS10)), .refill_cnt(refill_cnt),
    .dec(ack_ok && (sel == SEL_RS10)), .cnt(cnt10)
  );

  vend_coin_counter #(.CNT_W(CNT_W), .INIT(CNT_W'(INIT5))) u_cnt5 (
    .clk(clk), .rst(rst),
    .refill(refill_valid && (refill_sel == SEL_RS5)), .refill_cnt(refill_cnt),
    .dec(ack_ok && (sel == SEL_RS5)), .cnt(cnt5)
  );

`ifdef VEND_CHG_JAM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;
  logic             ejam_q;

  assign timed_out = (tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  tmr <= '0;
    else if (state == ST_PULSE)                tmr <= '0;
    else if (state == ST_WAIT_ACK && !disp_ack) tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       ejam_q <= 1'b0;
    else if (state_n == ST_DONE && state != ST_DONE) ejam_q <= jam_n;
  end

  assign err_jam = done & ejam_q;
`else
  assign timed_out = 1'b0;
  assign err_jam   = 1'b0;
`endif

  always_comb begin
    state_n = state;
    rem_n   = rem;
    sel_n   = sel;
    jam_n   = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        rem_n   = req_amt;
        state_n = (req_amt == '0) ? ST_DONE : ST_PICK;
      end
      ST_PICK: begin
        if (rem >= UNITS_RS10 && cnt10 != '0) begin
          sel_n   = SEL_RS10;
          state_n = ST_PULSE;
        end else if (cnt5 != '0) begin
          sel_n   = SEL_RS5;
          state_n = ST_PULSE;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_PULSE: state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (disp_ack) begin
          rem_n   = rem - coin_units(sel);
          state_n = (rem_n == '0) ? ST_DONE : ST_PICK;
        end else if (timed_out) begin
          jam_n   = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      rem   <= '0;
      sel   <= SEL_RS5;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      sel   <= sel_n;
    end
  end

  // Result is captured on entry to DONE so it lines up with the done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      short_amt <= '0;
      esh_q     <= 1'b0;
    end else if (state_n == ST_DONE && state != ST_DONE) begin
      short_amt <= rem_n;
      esh_q     <= (rem_n != '0) && !jam_n;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign disp_pulse = (state == ST_PULSE);
  assign disp_sel   = sel;
  assign done       = (state == ST_DONE);
  assign err_short  = done & esh_q;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Self-checking bench for vend_change_ctrl: fixed vector table, corner-case
// sequences and randomized requests against a greedy payout model.
module tb_vend_change_ctrl;
  import vend_pkg::*;

  localparam int CNT_W   = 4;
  localparam int INIT10  = 1;
  localparam int INIT5   = 0;
  localparam int TIMEOUT = 15;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [2:0]       req_amt = '0;
  logic             req_ready, disp_pulse, disp_sel;
  logic             disp_ack = 1'b0;
  logic             refill_valid = 1'b0;
  logic             refill_sel = 1'b0;
  logic [CNT_W-1:0] refill_cnt = '0;
  logic             done, err_short, err_jam;
  logic [2:0]       short_amt;
  logic [CNT_W-1:0] cnt10, cnt5;

  always #5 clk = ~clk;

  vend_change_ctrl #(.CNT_W(CNT_W), .INIT10(INIT10), .INIT5(INIT5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .disp_pulse(disp_pulse), .disp_sel(disp_sel), .disp_ack(disp_ack),
    .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_cnt(refill_cnt),
    .done(done), .short_amt(short_amt), .err_short(err_short), .err_jam(err_jam),
    .cnt10(cnt10), .cnt5(cnt5)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m10, m5;

  typedef struct {
    int r10; int r5; int amt; int dly;
    int np; int sels; int sh; int es; int c10; int c5;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Greedy payout from the current model inventory
  task automatic model(input int amt, output int np, output int sels, output int sh);
    int rem;
    rem = amt; np = 0; sels = 0;
    while (rem > 0) begin
      if (rem >= 2 && m10 > 0) begin
        sels |= (1 << np); np++; rem -= 2; m10--;
      end else if (m5 > 0) begin
        np++; rem -= 1; m5--;
      end else break;
    end
    sh = rem;
  endtask

  function automatic int exp_cyc(input int np, input int sh, input int dly);
    return (sh == 0) ? 1 + np * (dly + 2) : 2 + np * (dly + 2);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; disp_ack = 1'b0; refill_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m10 = INIT10; m5 = INIT5;
  endtask

  task automatic refill(input logic s, input int n);
    refill_valid = 1'b1; refill_sel = s; refill_cnt = n[CNT_W-1:0];
    @(negedge clk);
    refill_valid = 1'b0;
    if (s) m10 = sat(m10 + n); else m5 = sat(m5 + n);
  endtask

  // Issue one request and act as the hopper; returns at the negedge showing done.
  // coll > 0 adds a Rs.5 refill of that size in the same cycle as each ack.
  task automatic run_req(input int amt, input int dly, input int coll,
                         output int np, output int sels, output int sh,
                         output int es, output int ej, output int dcyc);
    int cd;
    bit got;
    np = 0; sels = 0; sh = -1; es = -1; ej = -1; dcyc = -1; cd = -1; got = 1'b0;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    if (!req_ready) chk("req_ready wait", 0, 1);
    req_valid = 1'b1; req_amt = amt[2:0];
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; disp_ack = 1'b0; refill_valid = 1'b0;
      if (cd > 0) cd--;
      if (cd == 0) begin
        disp_ack = 1'b1; cd = -1;
        if (coll > 0) begin
          refill_valid = 1'b1; refill_sel = SEL_RS5; refill_cnt = coll[CNT_W-1:0];
        end
      end
      if (done) begin
        got = 1'b1; sh = short_amt; es = err_short; ej = err_jam; dcyc = cyc;
        break;
      end else if (disp_pulse) begin
        sels |= (int'(disp_sel) << np); np++; cd = dly;
        req_valid = 1'b1; req_amt = 3'd7;  // must be ignored outside IDLE
      end
    end
    disp_ack = 1'b0; refill_valid = 1'b0; req_valid = 1'b0;
    if (!got) chk("done timeout", 0, 1);
  endtask

  initial begin
    int np, sels, sh, es, ej, dcyc, enp, esels, esh, amt, dly, ndone;

    tbl[0] = '{r10:0, r5:0,  amt:3, dly:2, np:1, sels:1, sh:1, es:1, c10:0, c5:0};
    tbl[1] = '{r10:0, r5:8,  amt:4, dly:1, np:4, sels:0, sh:0, es:0, c10:0, c5:4};
    tbl[2] = '{r10:8, r5:0,  amt:3, dly:2, np:2, sels:1, sh:0, es:0, c10:7, c5:3};
    tbl[3] = '{r10:0, r5:0,  amt:0, dly:1, np:0, sels:0, sh:0, es:0, c10:7, c5:3};
    tbl[4] = '{r10:0, r5:0,  amt:7, dly:3, np:4, sels:7, sh:0, es:0, c10:4, c5:2};
    tbl[5] = '{r10:0, r5:13, amt:1, dly:1, np:1, sels:0, sh:0, es:0, c10:4, c5:14};

    // Reset state while held in reset
    repeat (2) @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst disp_pulse", disp_pulse, 0);
    chk("rst disp_sel", disp_sel, 0);
    chk("rst done", done, 0);
    chk("rst short_amt", short_amt, 0);
    chk("rst err_short", err_short, 0);
    chk("rst err_jam", err_jam, 0);
    chk("rst cnt10", cnt10, INIT10);
    chk("rst cnt5", cnt5, INIT5);
    rst = 1'b1;
    @(negedge clk);

    // Fixed vectors, applied back to back from the reset inventory
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].r10 > 0) refill(SEL_RS10, tbl[i].r10);
      if (tbl[i].r5 > 0)  refill(SEL_RS5, tbl[i].r5);
      run_req(tbl[i].amt, tbl[i].dly, 0, np, sels, sh, es, ej, dcyc);
      chk($sformatf("t%0d pulses", i), np, tbl[i].np);
      chk($sformatf("t%0d sels", i), sels, tbl[i].sels);
      chk($sformatf("t%0d short_amt", i), sh, tbl[i].sh);
      chk($sformatf("t%0d err_short", i), es, tbl[i].es);
      chk($sformatf("t%0d err_jam", i), ej, 0);
      chk($sformatf("t%0d done cycle", i), dcyc, exp_cyc(tbl[i].np, tbl[i].sh, tbl[i].dly));
      chk($sformatf("t%0d cnt10", i), cnt10, tbl[i].c10);
      chk($sformatf("t%0d cnt5", i), cnt5, tbl[i].c5);
      @(negedge clk);
      chk($sformatf("t%0d done falls", i), done, 0);
      chk($sformatf("t%0d short holds", i), short_amt, tbl[i].sh);
    end

    // Refill saturation: 14 + 5 clamps at 15
    refill(SEL_RS5, 5);
    chk("sat cnt5", cnt5, 15);

    // Ack outside WAIT_ACK leaves inventory alone
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    @(negedge clk);
    chk("idle ack cnt5", cnt5, 15);
    chk("idle ack cnt10", cnt10, 4);
    chk("idle ack ready", req_ready, 1);

    // Refill of 3 in the same cycle as a Rs.5 ack at cnt5=6
    do_reset();
    refill(SEL_RS5, 6);
    run_req(1, 2, 3, np, sels, sh, es, ej, dcyc);
    chk("coll pulses", np, 1);
    chk("coll sel", sels, 0);
    chk("coll short", sh, 0);
    chk("coll cnt5", cnt5, 8);
    chk("coll cnt10", cnt10, INIT10);

    // Reset during WAIT_ACK
    do_reset();
    refill(SEL_RS5, 5);
    req_valid = 1'b1; req_amt = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst pulse seen", disp_pulse, 1);
    @(negedge clk);
    chk("midrst in wait", req_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst disp_pulse", disp_pulse, 0);
    chk("midrst req_ready", req_ready, 1);
    chk("midrst cnt10", cnt10, INIT10);
    chk("midrst cnt5", cnt5, INIT5);
    chk("midrst done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || disp_pulse) ndone++;
    end
    chk("midrst no activity", ndone, 0);
    m10 = INIT10; m5 = INIT5;

`ifdef VEND_CHG_JAM_TIMEOUT_EN
    // Missing ack: jam after TIMEOUT wait cycles, inventory untouched
    do_reset();
    refill(SEL_RS5, 3);
    run_req(2, -1, 0, np, sels, sh, es, ej, dcyc);
    chk("jam pulses", np, 1);
    chk("jam err_jam", ej, 1);
    chk("jam err_short", es, 0);
    chk("jam short", sh, 2);
    chk("jam done cycle", dcyc, 3 + TIMEOUT);
    chk("jam cnt10", cnt10, INIT10);
    chk("jam cnt5", cnt5, 3);
`endif

    // Randomized requests against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) refill(SEL_RS10, $urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) refill(SEL_RS5, $urandom_range(15, 0));
      amt = $urandom_range(7, 0);
      dly = $urandom_range(3, 1);
      model(amt, enp, esels, esh);
      run_req(amt, dly, 0, np, sels, sh, es, ej, dcyc);
      chk($sformatf("r%0d pulses", i), np, enp);
      chk($sformatf("r%0d sels", i), sels, esels);
      chk($sformatf("r%0d short", i), sh, esh);
      chk($sformatf("r%0d err_short", i), es, int'(esh != 0));
      chk($sformatf("r%0d err_jam", i), ej, 0);
      chk($sformatf("r%0d done cycle", i), dcyc, exp_cyc(enp, esh, dly));
      chk($sformatf("r%0d cnt10", i), cnt10, m10);
      chk($sformatf("r%0d cnt5", i), cnt5, m5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
